// File: rtl/reset_sequencer.sv
// reset_sequencer: power-up / lock-loss reset sequencer for the 25 MHz pixel domain.
// Synchronizes LOCKED, BTN and VGA_VSYNC, waits for a stable MMCM lock, holds the
// game core in reset, then waits for one full rendered frame before enabling video.
// Optional feature macro: BTN_DEBOUNCE_EN (button debounce filter on BTN_OUT).
module reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int DEBOUNCE_CYCLES    = 250000
) (
    input  logic       CLK_25MHZ,
    input  logic       RESET,
    input  logic       LOCKED,
    input  logic       BTN,
    input  logic       VGA_VSYNC,
    output logic       CORE_RESET,
    output logic       VIDEO_EN,
    output logic       BTN_OUT,
    output logic [2:0] STATE
);

    localparam logic [2:0] S_WAIT_LOCK  = 3'd0;
    localparam logic [2:0] S_STABILIZE  = 3'd1;
    localparam logic [2:0] S_HOLD_RESET = 3'd2;
    localparam logic [2:0] S_WAIT_FRAME = 3'd3;
    localparam logic [2:0] S_RUN        = 3'd4;

    // One shared counter serves both STABILIZE and HOLD_RESET; size it for the longer.
    localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                             LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);

    // Out-of-range parameters leave this block populated so it is visible in the
    // elaborated hierarchy; legal settings produce nothing.
    if ((LOCK_STABLE_CYCLES < 2) || (RESET_HOLD_CYCLES < 1) ||
        (DEBOUNCE_CYCLES < 2)) begin : g_param_out_of_range
        logic unused_marker;
        assign unused_marker = 1'b0;
    end

    // Saturating increment: counters hold at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : (v + CNT_W'(1));
    endfunction

    logic [1:0]       lock_sync_q;
    logic [1:0]       btn_sync_q;
    logic [1:0]       vs_sync_q;
    logic             vs_prev_q;
    logic             lock_s;
    logic             btn_s;
    logic             vs_s;
    logic             vs_fall;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             edge_seen_q, edge_seen_d;

    logic             core_reset_q, core_reset_d;
    logic             video_en_q, video_en_d;
    logic             btn_out_q, btn_out_d;

    assign lock_s  = lock_sync_q[1];
    assign btn_s   = btn_sync_q[1];
    assign vs_s    = vs_sync_q[1];
    assign vs_fall = vs_prev_q & ~vs_s;

    // Two-flop synchronizers for the asynchronous inputs plus VSYNC edge history.
    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            lock_sync_q <= 2'b00;
            btn_sync_q  <= 2'b00;
            vs_sync_q   <= 2'b00;
            vs_prev_q   <= 1'b0;
        end else begin
            lock_sync_q <= {lock_sync_q[0], LOCKED};
            btn_sync_q  <= {btn_sync_q[0], BTN};
            vs_sync_q   <= {vs_sync_q[0], VGA_VSYNC};
            vs_prev_q   <= vs_s;
        end
    end

    // FSM state and sequencing counters.
    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_WAIT_LOCK;
            cnt_q       <= '0;
            edge_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            edge_seen_q <= edge_seen_d;
        end
    end

    // Next-state and counter logic; lock loss overrides every other transition.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        edge_seen_d = edge_seen_q;
        case (state_q)
            S_WAIT_LOCK: begin
                cnt_d       = '0;
                edge_seen_d = 1'b0;
                if (lock_s) begin
                    state_d = S_STABILIZE;
                end else begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_STABILIZE: begin
                if (cnt_q == LOCK_LAST) begin
                    state_d = S_HOLD_RESET;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = sat_inc(cnt_q);
                end
            end
            S_HOLD_RESET: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_WAIT_FRAME;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = sat_inc(cnt_q);
                end
            end
            S_WAIT_FRAME: begin
                // The second VSYNC falling edge closes one complete frame.
                if (vs_fall) begin
                    if (edge_seen_q) begin
                        state_d     = S_RUN;
                        edge_seen_d = 1'b0;
                    end else begin
                        edge_seen_d = 1'b1;
                    end
                end else begin
                    edge_seen_d = edge_seen_q;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d     = S_WAIT_LOCK;
                cnt_d       = '0;
                edge_seen_d = 1'b0;
            end
        endcase
        if ((state_q != S_WAIT_LOCK) && !lock_s) begin
            state_d     = S_WAIT_LOCK;
            cnt_d       = '0;
            edge_seen_d = 1'b0;
        end else begin
            state_d     = state_d;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    // Debounce counter register.
    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_d;
        end
    end
`endif

    // Output decode from the next state so outputs change on the same edge as STATE.
    always_comb begin
        case (state_d)
            S_WAIT_FRAME: core_reset_d = 1'b0;
            S_RUN:        core_reset_d = 1'b0;
            default:      core_reset_d = 1'b1;
        endcase
        video_en_d = (state_d == S_RUN);
`ifdef BTN_DEBOUNCE_EN
        if (core_reset_d) begin
            btn_out_d = 1'b0;
            db_cnt_d  = '0;
        end else if (btn_s != btn_out_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_out_d = btn_s;
                db_cnt_d  = '0;
            end else begin
                btn_out_d = btn_out_q;
                db_cnt_d  = db_cnt_q + DB_W'(1);
            end
        end else begin
            btn_out_d = btn_out_q;
            db_cnt_d  = '0;
        end
`else
        if (core_reset_d) begin
            btn_out_d = 1'b0;
        end else begin
            btn_out_d = btn_s;
        end
`endif
    end

    // Registered outputs.
    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            core_reset_q <= 1'b1;
            video_en_q   <= 1'b0;
            btn_out_q    <= 1'b0;
        end else begin
            core_reset_q <= core_reset_d;
            video_en_q   <= video_en_d;
            btn_out_q    <= btn_out_d;
        end
    end

    assign CORE_RESET = core_reset_q;
    assign VIDEO_EN   = video_en_q;
    assign BTN_OUT    = btn_out_q;
    assign STATE      = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed testbench for reset_sequencer (LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4,
// DEBOUNCE_CYCLES=5). Cycle N means N rising edges after the stimulus change.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       locked;
    logic       btn;
    logic       vsync;
    logic       core_reset;
    logic       video_en;
    logic       btn_out;
    logic [2:0] state;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    reset_sequencer #(
        .LOCK_STABLE_CYCLES(8),
        .RESET_HOLD_CYCLES (4),
        .DEBOUNCE_CYCLES   (5)
    ) dut (
        .CLK_25MHZ (clk),
        .RESET     (rst),
        .LOCKED    (locked),
        .BTN       (btn),
        .VGA_VSYNC (vsync),
        .CORE_RESET(core_reset),
        .VIDEO_EN  (video_en),
        .BTN_OUT   (btn_out),
        .STATE     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // LOCKED has just risen (cycle 0); walk the lock/hold timing into WAIT_FRAME.
    task automatic lock_to_frame(input string tag);
        tick(2);  chk({tag, " c2 state"}, {5'd0, state}, 8'd0);
        tick(1);  chk({tag, " c3 state"}, {5'd0, state}, 8'd1);
                  chk({tag, " c3 core_reset"}, {7'd0, core_reset}, 8'd1);
        tick(7);  chk({tag, " c10 state"}, {5'd0, state}, 8'd1);
        tick(1);  chk({tag, " c11 state"}, {5'd0, state}, 8'd2);
        tick(3);  chk({tag, " c14 core_reset"}, {7'd0, core_reset}, 8'd1);
        tick(1);  chk({tag, " c15 state"}, {5'd0, state}, 8'd3);
                  chk({tag, " c15 core_reset"}, {7'd0, core_reset}, 8'd0);
                  chk({tag, " c15 video_en"}, {7'd0, video_en}, 8'd0);
    endtask

    // In WAIT_FRAME: two VSYNC falling edges, RUN on the edge after the second lands in vs_s.
    task automatic two_frames(input string tag);
        vsync = 1'b0;
        tick(2);
        vsync = 1'b1;
        tick(3);
        vsync = 1'b0;
        tick(2);  chk({tag, " 1st frame state"}, {5'd0, state}, 8'd3);
                  chk({tag, " 1st frame video_en"}, {7'd0, video_en}, 8'd0);
        tick(1);  chk({tag, " run state"}, {5'd0, state}, 8'd4);
                  chk({tag, " run video_en"}, {7'd0, video_en}, 8'd1);
                  chk({tag, " run core_reset"}, {7'd0, core_reset}, 8'd0);
        vsync = 1'b1;
    endtask

    initial begin
        rst    = 1'b1;
        locked = 1'b0;
        btn    = 1'b0;
        vsync  = 1'b1;
        tick(3);
        chk("reset state", {5'd0, state}, 8'd0);
        chk("reset core_reset", {7'd0, core_reset}, 8'd1);
        chk("reset video_en", {7'd0, video_en}, 8'd0);
        chk("reset btn_out", {7'd0, btn_out}, 8'd0);
        rst = 1'b0;
        tick(4);
        chk("no lock state", {5'd0, state}, 8'd0);

        // Power-up sequence with a button press confined to HOLD_RESET.
        locked = 1'b1;
        tick(2);  chk("pu c2 state", {5'd0, state}, 8'd0);
        tick(1);  chk("pu c3 state", {5'd0, state}, 8'd1);
        tick(7);  chk("pu c10 state", {5'd0, state}, 8'd1);
        tick(1);  chk("pu c11 state", {5'd0, state}, 8'd2);
        btn = 1'b1;
        tick(1);
        btn = 1'b0;
        tick(2);  chk("hold btn_out", {7'd0, btn_out}, 8'd0);
                  chk("pu c14 core_reset", {7'd0, core_reset}, 8'd1);
        tick(1);  chk("pu c15 state", {5'd0, state}, 8'd3);
                  chk("pu c15 core_reset", {7'd0, core_reset}, 8'd0);
                  chk("pu c15 btn_out", {7'd0, btn_out}, 8'd0);
        two_frames("pu");

        // Button held in RUN.
        btn = 1'b1;
        tick(2);  chk("run btn c2", {7'd0, btn_out}, 8'd0);
`ifdef BTN_DEBOUNCE_EN
        tick(4);  chk("run btn c6", {7'd0, btn_out}, 8'd0);
        tick(1);  chk("run btn c7", {7'd0, btn_out}, 8'd1);
`else
        tick(1);  chk("run btn c3", {7'd0, btn_out}, 8'd1);
`endif
        btn = 1'b0;
        tick(10); chk("run btn release", {7'd0, btn_out}, 8'd0);

`ifdef BTN_DEBOUNCE_EN
        // Bouncing button: 3-cycle runs never reach the 5-cycle filter.
        for (int i = 0; i < 10; i++) begin
            btn = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick(3);
            chk("bounce btn_out", {7'd0, btn_out}, 8'd0);
        end
        btn = 1'b1;
        tick(6);  chk("settle c6 btn_out", {7'd0, btn_out}, 8'd0);
        tick(1);  chk("settle c7 btn_out", {7'd0, btn_out}, 8'd1);
        btn = 1'b0;
        tick(10);
`endif

        // Lock loss in RUN and recovery.
        locked = 1'b0;
        tick(2);  chk("drop c2 state", {5'd0, state}, 8'd4);
                  chk("drop c2 video_en", {7'd0, video_en}, 8'd1);
        tick(1);  chk("drop c3 state", {5'd0, state}, 8'd0);
                  chk("drop c3 core_reset", {7'd0, core_reset}, 8'd1);
                  chk("drop c3 video_en", {7'd0, video_en}, 8'd0);
        locked = 1'b1;
        lock_to_frame("recov");
        two_frames("recov");

        // One-cycle lock glitch in STABILIZE at counter 5.
        locked = 1'b0;
        tick(3);  chk("glitch pre state", {5'd0, state}, 8'd0);
        locked = 1'b1;
        tick(3);  chk("glitch c3 state", {5'd0, state}, 8'd1);
        tick(3);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(1);  chk("glitch c8 state", {5'd0, state}, 8'd1);
        tick(1);  chk("glitch c9 state", {5'd0, state}, 8'd0);
                  chk("glitch c9 core_reset", {7'd0, core_reset}, 8'd1);
        tick(1);  chk("glitch c10 state", {5'd0, state}, 8'd1);
        tick(7);  chk("glitch c17 state", {5'd0, state}, 8'd1);
                  chk("glitch c17 core_reset", {7'd0, core_reset}, 8'd1);
        tick(1);  chk("glitch c18 state", {5'd0, state}, 8'd2);
                  chk("glitch c18 core_reset", {7'd0, core_reset}, 8'd1);

        // Asynchronous RESET pulse during HOLD_RESET with LOCKED high.
        tick(1);  chk("pre rst state", {5'd0, state}, 8'd2);
        rst = 1'b1;
        #2;
        chk("async rst state", {5'd0, state}, 8'd0);
        chk("async rst core_reset", {7'd0, core_reset}, 8'd1);
        chk("async rst video_en", {7'd0, video_en}, 8'd0);
        chk("async rst btn_out", {7'd0, btn_out}, 8'd0);
        rst = 1'b0;
        tick(2);  chk("post rst c2 state", {5'd0, state}, 8'd0);
        tick(1);  chk("post rst c3 state", {5'd0, state}, 8'd1);
        tick(8);  chk("post rst c11 state", {5'd0, state}, 8'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: synchronized LOCKED cycles required before the reset hold begins (range 2..65535).
REQ-002 SHALL have parameter RESET_HOLD_CYCLES, default 16: CORE_RESET hold length after lock is stable (range 1..255).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 250000: stable-input cycles for a button change, 10 ms at 25 MHz (range 2..2^20-1).
REQ-004 SHALL have port CLK_25MHZ  in  1  sole clock, pixel clock domain.
REQ-005 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port LOCKED  in  1  MMCM lock, asynchronous to CLK_25MHZ.
REQ-007 SHALL have port BTN  in  1  raw push-button, asynchronous, active-high.
REQ-008 SHALL have port VGA_VSYNC  in  1  vertical sync from the core, active-low.
REQ-009 SHALL have port CORE_RESET  out  1  registered, active-high reset to the game core.
REQ-010 SHALL have port VIDEO_EN  out  1  registered, gates RGB to zero when 0.
REQ-011 SHALL have port BTN_OUT  out  1  registered, conditioned button level.
REQ-012 SHALL have port STATE  out  3  current FSM state code.

Function
REQ-013 SHALL pass LOCKED, BTN and VGA_VSYNC each through a 2-flop synchronizer: lock_s, btn_s and vs_s.
REQ-014 SHALL implement states WAIT_LOCK=0, STABILIZE=1, HOLD_RESET=2, WAIT_FRAME=3 and RUN=4; codes 5-7 SHALL go to WAIT_LOCK on the next cycle.
REQ-015 WAIT_LOCK: on lock_s=1, go to STABILIZE and clear the counter; LOCKED rising therefore enters STABILIZE on the 3rd clock edge.
REQ-016 STABILIZE: increment the counter while lock_s=1; when the counter reaches LOCK_STABLE_CYCLES-1, go to HOLD_RESET and clear the counter.
REQ-017 HOLD_RESET: after RESET_HOLD_CYCLES cycles in this state, go to WAIT_FRAME.
REQ-018 WAIT_FRAME: count vs_s falling edges; on the 2nd edge, go to RUN (one full frame is guaranteed rendered before video is shown).
REQ-019 RUN: remain in RUN while lock_s=1.
REQ-020 In any state other than WAIT_LOCK, lock_s=0 SHALL force WAIT_LOCK on the next edge, clearing all counters; lock loss takes priority over every other transition in the same cycle.
REQ-021 CORE_RESET SHALL be 1 in WAIT_LOCK, STABILIZE and HOLD_RESET, and 0 in WAIT_FRAME and RUN; it is registered from the next state, so it is asserted the same edge the state changes.
REQ-022 VIDEO_EN SHALL be 1 only in RUN, registered the same way as CORE_RESET.
REQ-023 BTN_OUT SHALL be forced to 0 while CORE_RESET=1.
REQ-024 Counter widths SHALL be sized from the parameters; counters SHALL saturate and never wrap.
REQ-025 VGA_VSYNC edges SHALL be ignored outside WAIT_FRAME.

Reset
REQ-026 RESET=1 SHALL asynchronously force: state WAIT_LOCK, all synchronizer flops 0, all counters 0, CORE_RESET=1, VIDEO_EN=0, BTN_OUT=0, STATE=0.
REQ-027 After RESET deasserts, the sequence SHALL restart from WAIT_LOCK even if LOCKED is already high; RESET asserted mid-sequence SHALL abort it immediately.

Configuration
REQ-028 With macro BTN_DEBOUNCE_EN defined: BTN_OUT SHALL take the value of btn_s only after btn_s has differed from BTN_OUT for DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL clear the debounce counter.
REQ-029 Without BTN_DEBOUNCE_EN: BTN_OUT SHALL equal btn_s registered once (3-cycle latency from BTN), DEBOUNCE_CYCLES SHALL be unused, and no debounce counter SHALL be built.

Verification (LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4, DEBOUNCE_CYCLES=5)
REQ-030 LOCKED rises at cycle 0 and stays high -> STATE=1 at cycle 3, STATE=2 at cycle 11, CORE_RESET falls at cycle 15, and VIDEO_EN rises 2 VSYNC falling edges later.
REQ-031 LOCKED drops for 1 cycle during STABILIZE at counter=5 -> return to WAIT_LOCK, then a full 8-cycle restabilization; CORE_RESET stays 1 throughout.
REQ-032 LOCKED drops in RUN -> CORE_RESET=1, VIDEO_EN=0 and STATE=0 within 3 cycles of the drop; recovery repeats the REQ-030 timing.
REQ-033 Debounce enabled, BTN toggles every 3 cycles for 30 cycles, then held at 1 -> BTN_OUT stays 0 during toggling and rises exactly 5 cycles after btn_s settles.
REQ-034 RESET pulsed in HOLD_RESET with LOCKED high -> outputs reach reset values asynchronously, and the sequence restarts with STATE=1 three cycles after RESET falls.
REQ-035 Debounce disabled, BTN held at 1 while in RUN -> BTN_OUT=1 exactly 3 cycles later; BTN held at 1 during HOLD_RESET -> BTN_OUT=0.
